// File: rtl/sriz_mc_seq.sv
// Multi-cycle fetch/execute/memory/writeback sequencer with handshaked buses,
// ebreak halt, bus-timeout fault and retired-instruction counter.
module sriz_mc_seq #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000),
    parameter int unsigned     TIMEOUT  = 255,
    parameter int unsigned     CNT_W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    output logic            ifu_req_valid,
    input  logic            ifu_req_ready,
    output logic [XLEN-1:0] ifu_req_addr,
    input  logic            ifu_rsp_valid,
    input  logic [31:0]     ifu_rsp_inst,
    output logic [31:0]     inst,
    input  logic            dec_mem,
    input  logic            dec_regen,
    input  logic            dec_brk,
    input  logic [XLEN-1:0] exu_next_pc,
    output logic            lsu_req_valid,
    input  logic            lsu_req_ready,
    input  logic            lsu_rsp_valid,
    output logic [XLEN-1:0] pc,
    output logic            reg_wen,
    output logic            mem_en,
    output logic            halted,
    output logic            fault,
    output logic [XLEN-1:0] instret
);

    localparam logic [2:0] S_FETCH_REQ  = 3'd0;
    localparam logic [2:0] S_FETCH_WAIT = 3'd1;
    localparam logic [2:0] S_EXEC       = 3'd2;
    localparam logic [2:0] S_MEM_REQ    = 3'd3;
    localparam logic [2:0] S_MEM_WAIT   = 3'd4;
    localparam logic [2:0] S_WB         = 3'd5;
    localparam logic [2:0] S_HALT       = 3'd6;
    localparam logic [2:0] S_FAULT      = 3'd7;

    logic [2:0]       state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  instret_q, instret_d;
    logic [31:0]      inst_q, inst_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             timed_out;
    logic             bus_wait;

    assign timed_out = (tcnt_q == CNT_W'(TIMEOUT));
    assign bus_wait  = (state_q == S_FETCH_REQ) || (state_q == S_FETCH_WAIT) ||
                       (state_q == S_MEM_REQ)   || (state_q == S_MEM_WAIT);

    // Exit conditions are tested before the timeout so a response on the
    // last allowed cycle still completes normally.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instret_d = instret_q;
        inst_d    = inst_q;
        case (state_q)
            S_FETCH_REQ: begin
                if (ifu_req_ready)  state_d = S_FETCH_WAIT;
                else if (timed_out) state_d = S_FAULT;
            end
            S_FETCH_WAIT: begin
                if (ifu_rsp_valid) begin
                    inst_d  = ifu_rsp_inst;
                    state_d = S_EXEC;
                end else if (timed_out) begin
                    state_d = S_FAULT;
                end
            end
            S_EXEC: begin
                if (dec_brk)      state_d = S_HALT;
                else if (dec_mem) state_d = S_MEM_REQ;
                else              state_d = S_WB;
            end
            S_MEM_REQ: begin
                if (lsu_req_ready)  state_d = S_MEM_WAIT;
                else if (timed_out) state_d = S_FAULT;
            end
            S_MEM_WAIT: begin
                if (lsu_rsp_valid)  state_d = S_WB;
                else if (timed_out) state_d = S_FAULT;
            end
            S_WB: begin
                pc_d      = exu_next_pc;
                instret_d = instret_q + 1'b1;
                state_d   = S_FETCH_REQ;
            end
            default: state_d = state_q;
        endcase

        if (state_d != state_q) tcnt_d = '0;
        else if (bus_wait)      tcnt_d = tcnt_q + 1'b1;
        else                    tcnt_d = tcnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH_REQ;
            pc_q      <= RESET_PC;
            instret_q <= '0;
            inst_q    <= '0;
            tcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instret_q <= instret_d;
            inst_q    <= inst_d;
            tcnt_q    <= tcnt_d;
        end
    end

    // The reset state is FETCH_REQ, so the request is masked while rst is held.
    assign ifu_req_valid = (state_q == S_FETCH_REQ) && !rst;
    assign ifu_req_addr  = pc_q;
    assign pc            = pc_q;
    assign inst          = inst_q;
    assign instret       = instret_q;
    assign lsu_req_valid = (state_q == S_MEM_REQ);
    assign mem_en        = (state_q == S_MEM_REQ);
    assign reg_wen       = (state_q == S_WB) && dec_regen;
    assign halted        = (state_q == S_HALT);
    assign fault         = (state_q == S_FAULT);

endmodule

// File: tb/tb_sriz_mc_seq.sv
// Scoreboard bench for sriz_mc_seq: fetch/writeback events checked by a monitor,
// cycle-level timing checked inline by directed instruction vectors.
module tb_sriz_mc_seq;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] ADDI   = 32'h0010_0093;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [31:0] ifu_req_addr, ifu_rsp_inst, inst;
    logic        dec_mem, dec_regen, dec_brk;
    logic [31:0] exu_next_pc;
    logic        lsu_req_valid, lsu_req_ready, lsu_rsp_valid;
    logic [31:0] pc, instret;
    logic        reg_wen, mem_en, halted, fault;

    sriz_mc_seq #(
        .XLEN(32), .RESET_PC(RST_PC), .TIMEOUT(255), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_req_addr(ifu_req_addr), .ifu_rsp_valid(ifu_rsp_valid),
        .ifu_rsp_inst(ifu_rsp_inst), .inst(inst),
        .dec_mem(dec_mem), .dec_regen(dec_regen), .dec_brk(dec_brk),
        .exu_next_pc(exu_next_pc),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_rsp_valid(lsu_rsp_valid),
        .pc(pc), .reg_wen(reg_wen), .mem_en(mem_en),
        .halted(halted), .fault(fault), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] cnt;
    } fetch_t;

    fetch_t      exp_fetch[$];
    logic [31:0] exp_wb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc_cnt = 0;
    logic [31:0] m_pc, m_ret, m_inst;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_cnt++;
    endtask

    task automatic nedge();
        @(negedge clk);
    endtask

    // Monitor: every accepted fetch and every register write pops an expectation.
    initial begin
        fetch_t      f;
        logic [31:0] w;
        forever begin
            @(negedge clk);
            if (!rst && ifu_req_valid && ifu_req_ready) begin
                if (exp_fetch.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_fetch: got addr 0x%08h, expected no fetch", ifu_req_addr);
                end else begin
                    f = exp_fetch.pop_front();
                    check("fetch_addr", ifu_req_addr, f.addr);
                    check("fetch_instret", instret, f.cnt);
                end
            end
            if (!rst && reg_wen) begin
                if (exp_wb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_reg_wen: got pulse at pc 0x%08h, expected none", pc);
                end else begin
                    w = exp_wb.pop_front();
                    check("wb_pc", pc, w);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_inst = '0;
        dec_mem = 1'b0; dec_regen = 1'b0; dec_brk = 1'b0; exu_next_pc = '0;
        lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0;
        #1;
        check("rst_pc", pc, RST_PC);
        check("rst_req_addr", ifu_req_addr, RST_PC);
        check("rst_instret", instret, 0);
        check("rst_inst", inst, 0);
        check("rst_req_valid", ifu_req_valid, 0);
        check("rst_flags", {reg_wen, mem_en, lsu_req_valid, halted, fault}, 0);
        cyc();
        cyc();
        rst = 1'b0;
        m_pc = RST_PC; m_ret = '0; m_inst = '0;
    endtask

    // One instruction from FETCH_REQ back to FETCH_REQ; delays are cycles of
    // ready/rsp held low before the handshake.
    task automatic run_inst(input logic [31:0] iw, input logic mem, input logic regen,
                            input logic brk, input logic [31:0] npc,
                            input int rq, input int rs, input int lq, input int ls,
                            input bit abort_mw, output int lat);
        int     t0;
        fetch_t f;
        t0 = cyc_cnt;
        dec_mem = mem; dec_regen = regen; dec_brk = brk; exu_next_pc = npc;
        f.addr = m_pc; f.cnt = m_ret;
        exp_fetch.push_back(f);
        for (int i = 0; i < rq; i++) begin
            ifu_req_ready = 1'b0;
            nedge();
            check("req_valid_held", ifu_req_valid, 1);
            check("req_addr_held", ifu_req_addr, m_pc);
            cyc();
        end
        ifu_req_ready = 1'b1;
        nedge();
        check("req_valid_hs", ifu_req_valid, 1);
        cyc();
        ifu_req_ready = 1'b0;
        for (int i = 0; i < rs; i++) begin
            nedge();
            check("fetch_wait_no_req", ifu_req_valid, 0);
            check("inst_hold", inst, m_inst);
            cyc();
        end
        ifu_rsp_valid = 1'b1; ifu_rsp_inst = iw;
        nedge();
        check("inst_before_rsp_edge", inst, m_inst);
        cyc();
        ifu_rsp_valid = 1'b0; ifu_rsp_inst = 32'hDEAD_BEEF;
        m_inst = iw;
        nedge();
        check("exec_inst", inst, iw);
        check("exec_pc", pc, m_pc);
        check("exec_mem_en", mem_en, 0);
        check("exec_fault", fault, 0);
        cyc();
        if (brk) begin
            check("halted", halted, 1);
            check("halt_pc", pc, m_pc);
            lat = cyc_cnt - t0;
            return;
        end
        if (mem) begin
            for (int i = 0; i < lq; i++) begin
                lsu_req_ready = 1'b0;
                nedge();
                check("mem_req_mem_en", mem_en, 1);
                check("mem_req_valid", lsu_req_valid, 1);
                check("mem_req_pc", pc, m_pc);
                cyc();
            end
            lsu_req_ready = 1'b1;
            nedge();
            check("mem_hs_mem_en", mem_en, 1);
            cyc();
            lsu_req_ready = 1'b0;
            if (abort_mw) begin
                check("pre_abort_instret", instret, m_ret);
                rst = 1'b1;
                #1;
                check("abort_pc", pc, RST_PC);
                check("abort_instret", instret, 0);
                check("abort_reg_wen", reg_wen, 0);
                check("abort_mem_en", mem_en, 0);
                lsu_rsp_valid = 1'b1;
                cyc();
                cyc();
                rst = 1'b0;
                m_pc = RST_PC; m_ret = '0; m_inst = '0;
                for (int i = 0; i < 3; i++) begin
                    nedge();
                    check("late_rsp_reg_wen", reg_wen, 0);
                    check("late_rsp_mem_en", mem_en, 0);
                    check("late_rsp_fetch_req", ifu_req_valid, 1);
                    check("late_rsp_pc", pc, RST_PC);
                    check("late_rsp_instret", instret, 0);
                    cyc();
                end
                lsu_rsp_valid = 1'b0;
                lat = cyc_cnt - t0;
                return;
            end
            for (int i = 0; i < ls; i++) begin
                nedge();
                check("mem_wait_mem_en", mem_en, 0);
                check("mem_wait_reg_wen", reg_wen, 0);
                cyc();
            end
            lsu_rsp_valid = 1'b1;
            nedge();
            check("mem_rsp_mem_en", mem_en, 0);
            check("mem_rsp_reg_wen", reg_wen, 0);
            cyc();
            lsu_rsp_valid = 1'b0;
        end
        if (regen) exp_wb.push_back(m_pc);
        nedge();
        check("wb_reg_wen", reg_wen, regen);
        check("wb_pc_stable", pc, m_pc);
        cyc();
        m_pc = npc;
        m_ret = m_ret + 1;
        lat = cyc_cnt - t0;
        check("next_pc", pc, m_pc);
        check("instret", instret, m_ret);
    endtask

    task automatic fetch_timeout();
        fetch_t f;
        f.addr = m_pc; f.cnt = m_ret;
        exp_fetch.push_back(f);
        ifu_req_ready = 1'b1;
        cyc();
        ifu_req_ready = 1'b0;
        repeat (255) cyc();
        nedge();
        check("no_fault_before_limit", fault, 0);
        check("timeout_wait_no_req", ifu_req_valid, 0);
        cyc();
        check("fault_at_limit", fault, 1);
        check("fault_not_halted", halted, 0);
        ifu_rsp_valid = 1'b1; ifu_req_ready = 1'b1; ifu_rsp_inst = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            nedge();
            check("fault_sticky", fault, 1);
            check("fault_no_req", ifu_req_valid, 0);
            check("fault_pc", pc, m_pc);
            check("fault_instret", instret, m_ret);
            check("fault_inst", inst, m_inst);
            check("fault_reg_wen", reg_wen, 0);
            cyc();
        end
        ifu_rsp_valid = 1'b0; ifu_req_ready = 1'b0;
    endtask

    initial begin
        #100000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: got no end of stimulus, expected finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        do_reset();

        for (int k = 0; k < 3; k++) begin
            run_inst(ADDI, 1'b0, 1'b1, 1'b0, m_pc + 4, 0, 0, 0, 0, 1'b0, lat);
            check("alu_latency", lat, 4);
        end
        check("three_retired", instret, 3);
        check("pc_after_three", pc, 32'h8000_000C);

        run_inst(32'h0020_0113, 1'b0, 1'b1, 1'b0, m_pc + 4, 3, 4, 0, 0, 1'b0, lat);
        check("stalled_fetch_latency", lat, 11);

        run_inst(32'h0000_2183, 1'b1, 1'b1, 1'b0, m_pc + 4, 0, 0, 0, 0, 1'b0, lat);
        check("load_latency", lat, 6);
        run_inst(32'h0000_2183, 1'b1, 1'b1, 1'b0, m_pc + 4, 0, 0, 2, 2, 1'b0, lat);
        check("load_stalled_latency", lat, 10);
        run_inst(32'h0030_2023, 1'b1, 1'b0, 1'b0, m_pc + 4, 0, 0, 2, 2, 1'b0, lat);
        check("store_stalled_latency", lat, 10);

        run_inst(32'h1000_00EF, 1'b0, 1'b1, 1'b0, 32'h8000_0100, 0, 0, 0, 0, 1'b0, lat);
        check("jal_target_addr", ifu_req_addr, 32'h8000_0100);
        run_inst(ADDI, 1'b0, 1'b1, 1'b0, m_pc + 4, 0, 1, 0, 0, 1'b0, lat);

        run_inst(32'h0010_0073, 1'b0, 1'b0, 1'b1, m_pc + 4, 0, 0, 0, 0, 1'b0, lat);
        ifu_req_ready = 1'b1; ifu_rsp_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            nedge();
            check("halt_no_req", ifu_req_valid, 0);
            check("halt_sticky", halted, 1);
            check("halt_pc_frozen", pc, m_pc);
            check("halt_instret_frozen", instret, m_ret);
            check("halt_no_fault", fault, 0);
            cyc();
        end
        check("ebreak_not_retired", instret, 9);

        do_reset();
        run_inst(ADDI, 1'b0, 1'b1, 1'b0, m_pc + 4, 0, 255, 0, 0, 1'b0, lat);
        check("rsp_at_limit_latency", lat, 259);
        fetch_timeout();

        do_reset();
        run_inst(ADDI, 1'b0, 1'b1, 1'b0, m_pc + 4, 0, 0, 0, 0, 1'b0, lat);
        run_inst(32'h0000_2183, 1'b1, 1'b1, 1'b0, m_pc + 4, 0, 0, 1, 0, 1'b1, lat);
        run_inst(ADDI, 1'b0, 1'b1, 1'b0, m_pc + 4, 0, 0, 0, 0, 1'b0, lat);
        check("recovered_instret", instret, 1);

        cyc();
        cyc();
        check("fetch_queue_drained", exp_fetch.size(), 0);
        check("wb_queue_drained", exp_wb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
